nibble_serial_add_ctrl: RTL and testbench
=========================================

Name: nibble_serial_add_ctrl

Overview:
Sequencer that runs wide add/subtract operations through one shared 4-bit adder slice, one nibble per cycle, starting at the least significant nibble. A carry flip-flop chains the nibbles together. Operands are accepted on a valid/ready input handshake and results are returned on a valid/ready output handshake. It sits between the pin-level operand registers and the 4-bit adder datapath, so that designs wider than 4 bits reuse a single adder instance.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand (legal range 2..8). Operand width W = 4*NIBBLES.

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  controller can accept an operation
in_sub  input  1  0 = A+B, 1 = A-B
in_a  input  W  operand A
in_b  input  W  operand B
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_sum  output  W  result, modulo 2^W
out_cout  output  1  final carry out; for subtract, 1 = no borrow
out_ovf  output  1  two's-complement overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: rst is sampled on the clk rising edge only. After reset: state IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0, carry register=0, nibble index=0.
- Reset mid-operation: abort at that edge. The result is discarded, no out_valid pulse occurs, and the block returns to the reset state.
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a, b and sub.
  - Stored b = in_b XOR {W{in_sub}}; carry register = in_sub.
  - Nibble index = 0; go to RUN.
- RUN: each cycle the adder slice computes {c, s} = a[idx] + b[idx] + carry, using 5-bit arithmetic with no truncation before the carry is extracted.
  - s is written into the sum register at nibble idx; carry <= c; idx increments.
  - On the cycle where idx = NIBBLES-1:
    - out_cout = c.
    - out_ovf = (a_msb == b_msb_effective) && (s[3] != a_msb), where b_msb_effective is the already-inverted b for subtract.
    - Go to DONE.
  - RUN lasts exactly NIBBLES cycles.
- DONE:
  - out_valid=1; out_sum, out_cout and out_ovf are stable and held.
  - On an edge with out_ready=1, go to IDLE and clear out_valid. out_sum, out_cout and out_ovf keep their values.
  - With out_ready=0, hold indefinitely.
- Timing:
  - Latency: out_valid rises NIBBLES cycles after the accept edge.
  - Minimum spacing between accepts is NIBBLES+2 cycles when out_ready is held high.
- in_ready is 0 in RUN and DONE. in_valid in those states is ignored and is not queued. in_a, in_b and in_sub may change freely after the accept edge.
- Simultaneous events: in DONE, in_valid=1 together with out_ready=1 only completes the output handshake. The new request is accepted no earlier than the following IDLE edge.
- Wrap-around: the sum is modulo 2^W, and the carry out of the top nibble goes to out_cout only.
- Illegal state encodings return to IDLE.

Decomposition:
- Package nibble_add_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - NIBBLE_W = 4;
  - localparam function for the index width, clog2(NIBBLES).
- One sub-module: nibble_add_slice, a combinational 4-bit adder with carry-in (a, b, cin -> cout, sum). It is the shared datapath resource that the controller sequences. The controller contains the FSM, operand registers, nibble mux, carry register and result assembly.

Test Plan:
- NIBBLES=4, add 0x1234 + 0x4321 with out_ready=1 -> out_valid 4 cycles after accept; out_sum=0x5555, cout=0, ovf=0; out_valid high for 1 cycle.
- Add 0xFFFF + 0x0001 -> out_sum=0x0000, cout=1, ovf=0; checks carry ripple across all 4 nibbles.
- Subtract 0x0005 - 0x0007 -> out_sum=0xFFFE, cout=0 (borrow), ovf=0. Subtract 0x8000 - 0x0001 -> 0x7FFF, cout=1, ovf=1.
- Add 0x7FFF + 0x0001 with out_ready=0 for 10 cycles -> out_sum=0x8000, ovf=1; out_valid and data held all 10 cycles; in_ready=0 throughout even with in_valid=1; in_ready returns 1 the cycle after out_ready is asserted.
- Assert rst 2 cycles into RUN -> next cycle in_ready=1, out_valid=0, out_sum=0; no out_valid pulse; a new op, 0x0F0F + 0x00F1, then completes as 0x1000.
- Back-to-back: in_valid held high with out_ready=1 -> accepts spaced exactly 6 cycles; each result matches a scoreboard of random operands.

Source files
------------

// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
// State encoding, slice width and the nibble-index width helper live here.
package nibble_add_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Index width for counting 0..nibbles-1; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit adder slice with carry-in; the single shared datapath
// resource that the controller steps across the operand one nibble at a time.
module nibble_add_slice
    import nibble_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    // Full-width sum so the carry is taken before any truncation.
    logic [NIBBLE_W:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
        sum   = total[NIBBLE_W-1:0];
        cout  = total[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/subtract sequenced through one 4-bit slice, LSB nibble first, with a
// carry flip-flop chaining nibbles and valid/ready handshakes on both sides.
module nibble_serial_add_ctrl
    import nibble_add_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_sub,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
    output logic                        out_cout,
    output logic                        out_ovf,
    output logic                        busy
);

    localparam int unsigned W     = NIBBLE_W * NIBBLES;
    localparam int unsigned IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic              carry_q, carry_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;

    assign slice_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign slice_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

    nibble_add_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Subtract is A + ~B + 1: invert B here, inject the 1 as carry-in.
                    a_d     = in_a;
                    b_d     = in_b ^ {W{in_sub}};
                    carry_d = in_sub;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = slice_sum;
                carry_d = slice_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_sum[NIBBLE_W-1] != a_q[W-1]);
                    idx_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StRun) || (state_q == StDone);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed self-checking bench for nibble_serial_add_ctrl with NIBBLES=4.
module tb_nibble_serial_add_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_sub;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sub    (in_sub),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic [W-1:0] es, input logic ec,
                         input logic eo);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        tick();
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_sub   = ~sub;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
        tick();
        tick();
        tick();
        check({tag, "_valid_early"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"}, 32'(out_sum), 32'(es));
        check({tag, "_cout"}, 32'(out_cout), 32'(ec));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
        tick();
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] qa[$];
        logic [W-1:0] qs[$];
        logic         qc[$];
        logic         qo[$];
        logic [W-1:0] ra, rb;
        logic         rs;
        logic [W:0]   full;
        int           n_acc, n_res, last_acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sub    = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(out_sum), 32'd0);
        check("reset_cout", 32'(out_cout), 32'd0);
        check("reset_ovf", 32'(out_ovf), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        do_op("add_basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Output stall: result and flags must hold while the consumer is not ready.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 16'h7FFF;
        in_b      = 16'h0001;
        in_sub    = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_sum", 32'(out_sum), 32'h8000);
        check("stall_ovf", 32'(out_ovf), 32'd1);
        check("stall_cout", 32'(out_cout), 32'd0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            tick();
            check("stall_hold_valid", 32'(out_valid), 32'd1);
            check("stall_hold_sum", 32'(out_sum), 32'h8000);
            check("stall_hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("stall_release_in_ready", 32'(in_ready), 32'd1);
        check("stall_release_valid", 32'(out_valid), 32'd0);
        check("stall_release_sum", 32'(out_sum), 32'h8000);
        check("stall_release_ovf", 32'(out_ovf), 32'd1);

        // Reset two cycles into RUN aborts the operation with no result.
        in_valid = 1'b1;
        in_a     = 16'h1111;
        in_b     = 16'h2222;
        in_sub   = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(out_sum), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_pulse", 32'(out_valid), 32'd0);
        end
        do_op("after_abort", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Back-to-back with in_valid held high: accepts every N+2 cycles.
        n_acc    = 0;
        n_res    = 0;
        last_acc = 0;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 80 && n_res < 4; cyc++) begin
            if (out_valid) begin
                if (n_res < qs.size()) begin
                    check("b2b_sum", 32'(out_sum), 32'(qs[n_res]));
                    check("b2b_cout", 32'(out_cout), 32'(qc[n_res]));
                    check("b2b_ovf", 32'(out_ovf), 32'(qo[n_res]));
                end else begin
                    check("b2b_unexpected_result", 32'(out_valid), 32'd0);
                end
                n_res++;
            end
            if (in_ready && n_acc < 4) begin
                ra = W'($urandom);
                rb = W'($urandom);
                rs = 1'($urandom);
                if (rs) begin
                    full = {1'b0, ra} + {1'b0, ~rb} + 17'd1;
                    qo.push_back((ra[W-1] != rb[W-1]) && (full[W-1] != ra[W-1]));
                end else begin
                    full = {1'b0, ra} + {1'b0, rb};
                    qo.push_back((ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]));
                end
                qa.push_back(ra);
                qs.push_back(full[W-1:0]);
                qc.push_back(full[W]);
                if (n_acc > 0) begin
                    check("b2b_spacing", 32'(cyc - last_acc), 32'(N + 2));
                end
                last_acc = cyc;
                n_acc++;
                in_a     = ra;
                in_b     = rb;
                in_sub   = rs;
                in_valid = 1'b1;
            end else begin
                in_valid = (n_acc < 4);
                in_a     = W'($urandom);
                in_b     = W'($urandom);
                in_sub   = 1'($urandom);
            end
            tick();
        end
        in_valid = 1'b0;
        check("b2b_results_seen", 32'(n_res), 32'd4);
        check("b2b_accepts", 32'(qa.size()), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
